// File: rtl/wb_stage_pkg.sv
// Shared pipeline types for the write-back stage: datapath widths, the
// hardwired-zero register index and the MEM/WB register field grouping.
// Latency: n/a (types only). Backpressure: n/a.
package wb_stage_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  // Register 0 reads as zero and is never written or bypassed.
  localparam logic [REG_AW-1:0] ZERO_REG = '0;

  // Fields carried from MEM into WB.
  typedef struct packed {
    logic              valid;
    logic              regWrite;
    logic              MemtoReg;
    logic [DATA_W-1:0] readData;
    logic [DATA_W-1:0] aluResult;
    logic [REG_AW-1:0] writeRegi;
  } mem_wb_t;

endpackage

// File: rtl/wb_bypass_cmp.sv
// Bypass compare for one decode read port against the current write and the
// one-entry write history. Purely combinational, no backpressure.
// Ports: rd_addr (read address); wr_* (current write); hist_* (history entry);
//        hit/data (bypass result, data is 0 when hit is 0).
module wb_bypass_cmp
  import wb_stage_pkg::*;
#(
  parameter int DATA_W = wb_stage_pkg::DATA_W,
  parameter int REG_AW = wb_stage_pkg::REG_AW
) (
  input  logic [REG_AW-1:0] rd_addr,
  input  logic              wr_en,
  input  logic [REG_AW-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              hist_valid,
  input  logic [REG_AW-1:0] hist_addr,
  input  logic [DATA_W-1:0] hist_data,
  output logic              hit,
  output logic [DATA_W-1:0] data
);

  always_comb begin
    hit  = 1'b0;
    data = '0;
    if (rd_addr != ZERO_REG) begin
      // The write landing this cycle is newer than anything in history.
      if (wr_en && (wr_addr == rd_addr)) begin
        hit  = 1'b1;
        data = wr_data;
      end else if (hist_valid && (hist_addr == rd_addr)) begin
        hit  = 1'b1;
        data = hist_data;
      end
    end
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB register, result select, single register-file
// write port, one-entry write history with decode bypass, retire counter.
// Latency: write port driven the cycle after MEM load; stall holds the entry
// and it writes/retires only once; flush overrides stall and inserts a bubble.
// Ports: clk/rst; stall/flush; mem_* (MEM stage inputs); regWrite/WriteData/
//        writeRegi (RF write); id_rs/id_rt -> byp_hit*/byp_data*; retired_count.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int DATA_W = wb_stage_pkg::DATA_W,
  parameter int REG_AW = wb_stage_pkg::REG_AW,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              mem_valid,
  input  logic              mem_regWrite,
  input  logic              mem_MemtoReg,
  input  logic [DATA_W-1:0] mem_readData,
  input  logic [DATA_W-1:0] mem_aluResult,
  input  logic [REG_AW-1:0] mem_writeRegi,
  output logic              regWrite,
  output logic [DATA_W-1:0] WriteData,
  output logic [REG_AW-1:0] writeRegi,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  output logic              byp_hit1,
  output logic [DATA_W-1:0] byp_data1,
  output logic              byp_hit2,
  output logic [DATA_W-1:0] byp_data2,
  output logic [CNT_W-1:0]  retired_count
);

  mem_wb_t           mem_in;
  mem_wb_t           wb_q;
  logic              written;
  logic              first_cycle;
  logic              hist_valid;
  logic [REG_AW-1:0] hist_addr;
  logic [DATA_W-1:0] hist_data;
  logic [CNT_W-1:0]  cnt_q;

  assign mem_in = '{valid:     mem_valid,
                    regWrite:  mem_regWrite,
                    MemtoReg:  mem_MemtoReg,
                    readData:  mem_readData,
                    aluResult: mem_aluResult,
                    writeRegi: mem_writeRegi};

  // An entry held by stall must write and retire exactly once: only its
  // first cycle in WB counts.
  assign first_cycle = wb_q.valid & ~written;

  assign regWrite  = first_cycle & wb_q.regWrite & (wb_q.writeRegi != ZERO_REG);
  assign WriteData = wb_q.MemtoReg ? wb_q.readData : wb_q.aluResult;
  assign writeRegi = wb_q.writeRegi;
  assign retired_count = cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_q    <= '0;
      written <= 1'b0;
    end else if (flush) begin
      wb_q    <= '0;
      written <= 1'b0;
    end else if (stall) begin
      if (wb_q.valid) begin
        written <= 1'b1;
      end
    end else begin
      wb_q    <= mem_in;
      written <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_valid <= 1'b0;
      hist_addr  <= '0;
      hist_data  <= '0;
    end else if (regWrite) begin
      hist_valid <= 1'b1;
      hist_addr  <= writeRegi;
      hist_data  <= WriteData;
    end
  end

  // Counts the entry leaving WB even when a flush lands on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (first_cycle) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  wb_bypass_cmp #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_byp1 (
    .rd_addr    (id_rs),
    .wr_en      (regWrite),
    .wr_addr    (writeRegi),
    .wr_data    (WriteData),
    .hist_valid (hist_valid),
    .hist_addr  (hist_addr),
    .hist_data  (hist_data),
    .hit        (byp_hit1),
    .data       (byp_data1)
  );

  wb_bypass_cmp #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_byp2 (
    .rd_addr    (id_rt),
    .wr_en      (regWrite),
    .wr_addr    (writeRegi),
    .wr_data    (WriteData),
    .hist_valid (hist_valid),
    .hist_addr  (hist_addr),
    .hist_data  (hist_data),
    .hit        (byp_hit2),
    .data       (byp_data2)
  );

endmodule
